fifo_skew_scheduler: RTL and testbench

Read-side sequencer for the bank of per-row input FIFOs that feed the systolic array. On a start pulse it drains LEN elements from each of ROWS FIFOs, with row i delayed i cycles to produce the diagonal wavefront the array expects. It produces a per-row valid aligned with the FIFOs' registered out_data. If any FIFO scheduled in a cycle is empty, it stalls the whole wavefront so the skew between rows is preserved.

---
 rtl/fifo_skew_scheduler_pkg.sv | 19 +
 rtl/fifo_skew_window.sv | 26 ++
 rtl/fifo_skew_scheduler.sv | 128 ++++++++++++
 tb/tb_fifo_skew_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_skew_scheduler_pkg.sv
// Shared types for the systolic-array FIFO read sequencer.
// State encoding and stall-counter helpers.
package fifo_skew_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int STALL_CNT_W = 16;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(
    input logic [STALL_CNT_W-1:0] v
  );
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_skew_window.sv
// Per-row schedule window: row ROW_IDX is live
// while ROW_IDX <= t < ROW_IDX+LEN in RUN.
module fifo_skew_window #(
  parameter int ROW_IDX = 0,
  parameter int LEN     = 8,
  parameter int CNT_W   = 4
) (
  input  logic [CNT_W-1:0] t,
  input  logic             run,
  output logic             scheduled
);

  localparam logic [CNT_W-1:0] HI = CNT_W'(ROW_IDX + LEN);

  logic lo_ok;

  if (ROW_IDX == 0) begin : g_lo_zero
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    localparam logic [CNT_W-1:0] LO = CNT_W'(ROW_IDX);
    assign lo_ok = (t >= LO);
  end

  assign scheduled = run & lo_ok & (t < HI);

endmodule

// File: rtl/fifo_skew_scheduler.sv
// Skewed read sequencer for the row FIFOs feeding the array.
// Whole wavefront freezes when any scheduled row is empty.
module fifo_skew_scheduler
  import fifo_skew_scheduler_pkg::*;
#(
  parameter  int ROWS  = 4,
  parameter  int LEN   = 8,
  localparam int CNT_W = $clog2(LEN + ROWS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ROWS-1:0]        fifo_empty,
  output logic [ROWS-1:0]        fifo_r_en,
  output logic [ROWS-1:0]        valid_out,
  output logic                   busy,
  output logic                   stall,
  output logic                   done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LEN + ROWS - 2);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       t_q, t_d;
  logic [ROWS-1:0]        valid_q, valid_d;
  logic [STALL_CNT_W-1:0] scnt_q, scnt_d;
  logic [ROWS-1:0]        sched;
  logic [ROWS-1:0]        r_en;
  logic                   run;
  logic                   stall_w;

  assign run = (state_q == ST_RUN);

  for (genvar i = 0; i < ROWS; i++) begin : g_win
    fifo_skew_window #(
      .ROW_IDX(i),
      .LEN    (LEN),
      .CNT_W  (CNT_W)
    ) u_win (
      .t        (t_q),
      .run      (run),
      .scheduled(sched[i])
    );
  end

  // Stall if any live row is empty; reads only on clean cycles.
  always_comb begin
    stall_w = |(sched & fifo_empty);
    r_en    = '0;
    if (!stall_w && !abort) begin
      r_en = sched;
    end
  end

  // Next state, wavefront counter, stall counter, valid.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    scnt_d  = scnt_q;
    valid_d = r_en;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          t_d     = '0;
          scnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (stall_w) begin
          scnt_d = sat_inc(scnt_q);
        end
        if (abort) begin
          state_d = ST_IDLE;
          t_d     = '0;
        end else if (!stall_w) begin
          t_d = t_q + CNT_W'(1);
          if (t_q == T_LAST) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      valid_q <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      scnt_q  <= scnt_d;
    end
  end

  assign fifo_r_en = r_en;
  assign valid_out = valid_q;
  assign stall     = stall_w;
  assign done      = (state_q == ST_FLUSH);
  assign busy      = (state_q == ST_RUN) | (state_q == ST_FLUSH);
  assign stall_cnt = scnt_q;

  a_no_rd_empty: assert property (
    @(posedge clk) disable iff (!rstn)
    (fifo_r_en & fifo_empty) == '0
  );

  a_stall_quiet: assert property (
    @(posedge clk) disable iff (!rstn)
    stall |-> (fifo_r_en == '0)
  );

endmodule

// File: tb/tb_fifo_skew_scheduler.sv
// Bench for fifo_skew_scheduler: FIFO model with data
// scoreboard plus per-cycle wavefront timing table.
module tb_fifo_skew_scheduler;

  localparam int ROWS = 4;
  localparam int LEN  = 8;
  localparam int TLEN = LEN + ROWS;

  logic            clk   = 1'b0;
  logic            rstn  = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [ROWS-1:0] fifo_empty = '1;
  logic [ROWS-1:0] fifo_r_en;
  logic [ROWS-1:0] valid_out;
  logic            busy, stall, done;
  logic [15:0]     stall_cnt;

  logic        start1 = 1'b0;
  logic        abort1 = 1'b0;
  logic [0:0]  empty1 = 1'b0;
  logic [0:0]  ren1, vld1;
  logic        busy1, stall1, done1;
  logic [15:0] scnt1;

  int n_chk  = 0;
  int n_pass = 0;

  int mem[ROWS][$];
  int exp_q[ROWS][$];
  int out_data[ROWS];
  int seq[ROWS];
  int rdn[ROWS];

  logic ld = 1'b0;
  int   ld_n[ROWS];
  int   gap_row = -1;
  int   gap_rd  = 0;
  int   gap_dly = 0;
  int   gap_n   = 0;
  int   tmr     = 0;

  fifo_skew_scheduler #(.ROWS(ROWS), .LEN(LEN)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .fifo_empty(fifo_empty),
    .fifo_r_en (fifo_r_en),
    .valid_out (valid_out),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  fifo_skew_scheduler #(.ROWS(1), .LEN(1)) u_dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start1),
    .abort     (abort1),
    .fifo_empty(empty1),
    .fifo_r_en (ren1),
    .valid_out (vld1),
    .busy      (busy1),
    .stall     (stall1),
    .done      (done1),
    .stall_cnt (scnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic void push(input int r);
    mem[r].push_back(r * 1000 + seq[r]);
    exp_q[r].push_back(r * 1000 + seq[r]);
    seq[r]++;
  endfunction

  // Row FIFO model: one-cycle read latency, registered empty.
  always @(posedge clk) begin
    logic [ROWS-1:0] emp;
    if (tmr != 0) begin
      if (tmr == 1) begin
        for (int k = 0; k < gap_n; k++) push(gap_row);
      end
      tmr--;
    end
    if (ld) tmr = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (ld) begin
        mem[i].delete();
        exp_q[i].delete();
        rdn[i] = 0;
        for (int k = 0; k < ld_n[i]; k++) push(i);
      end else if (fifo_r_en[i]) begin
        chk($sformatf("rd_nonempty_r%0d", i),
            (mem[i].size() != 0) ? 1 : 0, 1);
        if (mem[i].size() != 0) out_data[i] <= mem[i].pop_front();
        rdn[i]++;
        if (i == gap_row && rdn[i] == gap_rd) tmr = gap_dly;
      end
      emp[i] = (mem[i].size() == 0);
    end
    fifo_empty <= emp;
  end

  // Scoreboard: each valid beat must carry the next element.
  always @(negedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (valid_out[i]) begin
        chk($sformatf("sb_r%0d", i), out_data[i],
            (exp_q[i].size() != 0) ? exp_q[i][0] : -1);
        if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
      end
    end
  end

  task automatic set_load(input int a, input int b,
                          input int c, input int d);
    ld_n[0] = a;
    ld_n[1] = b;
    ld_n[2] = c;
    ld_n[3] = d;
  endtask

  // Called mid cycle 0; checks cycles 1..ncyc.
  task automatic run_tile(input string nm, input int ncyc,
                          input int st_from, input int st_len,
                          input int ab_c, input int s1,
                          input int s2);
    logic [ROWS-1:0] er, ev;
    int e;
    bit ins, aft, fin;
    start = 1'b1;
    ld    = 1'b1;
    ev    = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      ld    = 1'b0;
      start = (c == s1 || c == s2);
      abort = (c == ab_c);
      #1;
      ins = st_len > 0 && c >= st_from && c < st_from + st_len;
      e   = (st_len > 0 && c >= st_from + st_len) ? c - st_len : c;
      aft = ab_c > 0 && c > ab_c;
      fin = !ins && !aft && e == TLEN;
      er  = '0;
      if (!ins && !aft && c != ab_c) begin
        for (int i = 0; i < ROWS; i++)
          if (e >= 1 + i && e <= i + LEN) er[i] = 1'b1;
      end
      chk($sformatf("%s c%0d r_en", nm, c), 32'(fifo_r_en), 32'(er));
      chk($sformatf("%s c%0d valid", nm, c), 32'(valid_out), 32'(ev));
      chk($sformatf("%s c%0d stall", nm, c), 32'(stall), 32'(ins));
      chk($sformatf("%s c%0d done", nm, c), 32'(done), 32'(fin));
      chk($sformatf("%s c%0d busy", nm, c), 32'(busy),
          32'(!aft && (ins || (e >= 1 && e <= TLEN))));
      if (fin)
        chk($sformatf("%s stall_cnt", nm), 32'(stall_cnt), st_len);
      ev = er;
    end
    abort = 1'b0;
    if (ab_c == 0 && ncyc >= TLEN + st_len) begin
      for (int i = 0; i < ROWS; i++)
        chk($sformatf("%s drain_r%0d", nm, i), exp_q[i].size(), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < ROWS; i++) ld_n[i] = 0;
    #1 rstn = 1'b0;
    #1;
    chk("rst r_en", 32'(fifo_r_en), 0);
    chk("rst valid", 32'(valid_out), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst stall_cnt", 32'(stall_cnt), 0);
    #20;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    set_load(8, 8, 8, 8);
    run_tile("nom", TLEN + 1, 0, 0, 0, 0, 0);

    set_load(8, 3, 8, 8);
    gap_row = 1;
    gap_rd  = 3;
    gap_dly = 5;
    gap_n   = 5;
    run_tile("stl", TLEN + 6, 5, 5, 0, 0, 0);
    gap_row = -1;

    set_load(8, 8, 8, 8);
    run_tile("b2b_a", TLEN, 0, 0, 0, 5, 12);
    @(negedge clk);
    #1 chk("b2b idle c13", 32'(busy), 0);
    run_tile("b2b_b", TLEN + 1, 0, 0, 0, 0, 0);

    run_tile("abt", 10, 0, 0, 6, 0, 0);
    run_tile("post_abt", TLEN + 1, 0, 0, 0, 0, 0);

    run_tile("rst_mid", 4, 0, 0, 0, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("arst r_en", 32'(fifo_r_en), 0);
    chk("arst valid", 32'(valid_out), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst done", 32'(done), 0);
    chk("arst stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d busy", k), 32'(busy), 0);
      chk($sformatf("post_rst%0d r_en", k), 32'(fifo_r_en), 0);
      chk($sformatf("post_rst%0d valid", k), 32'(valid_out), 0);
    end

    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    #1;
    chk("deg c1 r_en", 32'(ren1), 1);
    chk("deg c1 busy", 32'(busy1), 1);
    chk("deg c1 done", 32'(done1), 0);
    chk("deg c1 stall", 32'(stall1), 0);
    @(negedge clk);
    #1;
    chk("deg c2 valid", 32'(vld1), 1);
    chk("deg c2 done", 32'(done1), 1);
    chk("deg c2 r_en", 32'(ren1), 0);
    @(negedge clk);
    #1;
    chk("deg c3 busy", 32'(busy1), 0);
    chk("deg c3 valid", 32'(vld1), 0);
    chk("deg stall_cnt", 32'(scnt1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
